// File: rtl/uart_baud_pkg.sv
// rtl/uart_baud_pkg.sv - shared defaults, reset divisor and config type for the oversampling baud generator
package uart_baud_pkg;

  localparam int DIV_W_DEF        = 16;
  localparam int FRAC_W_DEF       = 4;
  localparam int OSR_DEF          = 16;
  // 100 MHz clock, 115200 baud, 16x oversampling: 100e6 / (115200 * 16) = 54.25
  localparam int RST_DIV_INT_DEF  = 54;
  localparam int RST_DIV_FRAC_DEF = 4;

  typedef struct packed {
    logic [DIV_W_DEF-1:0]  div_int;
    logic [FRAC_W_DEF-1:0] div_frac;
  } baud_cfg_t;

endpackage

// File: rtl/uart_baud_os_gen_if.sv
// rtl/uart_baud_os_gen_if.sv - control/strobe bundle between CSR block, baud generator and uart_tx/uart_rx
interface uart_baud_os_gen_if
  import uart_baud_pkg::*;
#(
  parameter int DIV_W  = DIV_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
);

  logic              en;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              cfg_load;
  logic              rx_resync;
  logic              os_tick;
  logic              mid_tick;
  logic              bit_tick;
  logic              cfg_pending;
  logic              cfg_err;

  modport master (
    output en, div_int, div_frac, cfg_load, rx_resync,
    input  os_tick, mid_tick, bit_tick, cfg_pending, cfg_err
  );

  modport slave (
    input  en, div_int, div_frac, cfg_load, rx_resync,
    output os_tick, mid_tick, bit_tick, cfg_pending, cfg_err
  );

endinterface

// File: rtl/uart_frac_accum.sv
// rtl/uart_frac_accum.sv - fractional divisor accumulator, only built when UART_BAUD_FRAC_EN is defined
`ifdef UART_BAUD_FRAC_EN
module uart_frac_accum #(
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              step_i,
  input  logic [FRAC_W-1:0] frac_i,
  output logic              carry_o
);

  logic [FRAC_W-1:0] acc_q;
  logic              carry_q;
  logic [FRAC_W:0]   sum_d;

  assign sum_d   = {1'b0, acc_q} + {1'b0, frac_i};
  assign carry_o = carry_q;

  // Add the fraction once per period; the carry stretches the following period by one clock
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else if (step_i) begin
      {carry_q, acc_q} <= sum_d;
    end
  end

endmodule
`endif

// File: rtl/uart_baud_os_gen.sv
// rtl/uart_baud_os_gen.sv - fractional oversampling baud generator; UART_BAUD_FRAC_EN enables the fractional divisor
module uart_baud_os_gen
  import uart_baud_pkg::*;
#(
  parameter int DIV_W        = DIV_W_DEF,
  parameter int FRAC_W       = FRAC_W_DEF,
  parameter int OSR          = OSR_DEF,
  parameter int RST_DIV_INT  = RST_DIV_INT_DEF,
  parameter int RST_DIV_FRAC = RST_DIV_FRAC_DEF
) (
  input logic               clk,
  input logic               rst,
  uart_baud_os_gen_if.slave baud
);

  localparam int OS_W = $clog2(OSR);

  typedef struct packed {
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
  } cfg_t;

  localparam cfg_t RST_CFG = '{div_int: DIV_W'(RST_DIV_INT), div_frac: FRAC_W'(RST_DIV_FRAC)};

  logic             en_d_q;
  logic [DIV_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
  cfg_t             act_q, act_d;
  cfg_t             pend_q, pend_d;
  logic             pend_flag_q, pend_flag_d;
  logic             os_tick_q, mid_tick_q, bit_tick_q, cfg_err_q;

  logic             restart;
  logic             stall;
  logic             period_end;
  logic             apply;
  logic             carry;
  logic [DIV_W:0]   last_cnt;

  // Disabled, freshly enabled, or resynced to an RX start edge: phase restarts from zero
  assign restart    = ~baud.en | ~en_d_q | baud.rx_resync;
  // A zero integer divisor cannot produce a period, so the counter is parked
  assign stall      = (act_q.div_int == '0);
  assign last_cnt   = {1'b0, act_q.div_int} + {{DIV_W{1'b0}}, carry} - {{DIV_W{1'b0}}, 1'b1};
  assign period_end = ~restart & ~stall & ({1'b0, clk_cnt_q} == last_cnt);
  // New divisors only take effect on a period boundary; a stalled generator has none, so it takes them at once
  assign apply      = pend_flag_q & (restart | period_end | stall);

`ifdef UART_BAUD_FRAC_EN
  uart_frac_accum #(
    .FRAC_W(FRAC_W)
  ) u_frac_accum (
    .clk    (clk),
    .rst    (rst),
    .clear_i(restart),
    .step_i (period_end),
    .frac_i (act_q.div_frac),
    .carry_o(carry)
  );
`else
  // Integer-only build: div_frac still travels through the config path but nothing consumes it
  logic unused_frac;
  assign carry       = 1'b0;
  assign unused_frac = ^act_q.div_frac;
`endif

  // Pending/active divisor bookkeeping; a load on the apply edge stays pending for the next boundary
  always_comb begin
    act_d       = act_q;
    pend_d      = pend_q;
    pend_flag_d = pend_flag_q;
    if (apply) begin
      act_d       = pend_q;
      pend_flag_d = 1'b0;
    end
    if (baud.cfg_load) begin
      pend_d      = '{div_int: baud.div_int, div_frac: baud.div_frac};
      pend_flag_d = 1'b1;
    end
  end

  // Clock counter within a period and oversample index within a bit
  always_comb begin
    clk_cnt_d = clk_cnt_q + DIV_W'(1);
    os_cnt_d  = os_cnt_q;
    if (restart || stall || period_end) begin
      clk_cnt_d = '0;
    end
    if (restart) begin
      os_cnt_d = '0;
    end else if (period_end) begin
      os_cnt_d = (os_cnt_q == OS_W'(OSR - 1)) ? '0 : os_cnt_q + OS_W'(1);
    end
  end

  // State and registered strobes; bit/mid qualify on the oversample index before it advances
  always_ff @(posedge clk) begin
    if (rst) begin
      en_d_q      <= 1'b0;
      clk_cnt_q   <= '0;
      os_cnt_q    <= '0;
      act_q       <= RST_CFG;
      pend_q      <= RST_CFG;
      pend_flag_q <= 1'b0;
      os_tick_q   <= 1'b0;
      mid_tick_q  <= 1'b0;
      bit_tick_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      en_d_q      <= baud.en;
      clk_cnt_q   <= clk_cnt_d;
      os_cnt_q    <= os_cnt_d;
      act_q       <= act_d;
      pend_q      <= pend_d;
      pend_flag_q <= pend_flag_d;
      os_tick_q   <= period_end;
      mid_tick_q  <= period_end && (os_cnt_q == OS_W'(OSR / 2 - 1));
      bit_tick_q  <= period_end && (os_cnt_q == OS_W'(OSR - 1));
      cfg_err_q   <= (act_d.div_int == '0);
    end
  end

  assign baud.os_tick     = os_tick_q;
  assign baud.mid_tick    = mid_tick_q;
  assign baud.bit_tick    = bit_tick_q;
  assign baud.cfg_pending = pend_flag_q;
  assign baud.cfg_err     = cfg_err_q;

endmodule
